id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/reg_file.sv | 45 ++++
 rtl/id_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, control bundle and immediate generator
// used by the instruction-decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_LUI    = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  // Returns the 32-bit sign-extended immediate; B and J keep bit 0 cleared.
  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry 2R1W register file with write-first bypass; x0 is hardwired to zero.
module reg_file #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [4:0]           wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [4:0]           rd1_addr,
  input  logic [4:0]           rd2_addr,
  output logic [WORD_SIZE-1:0] rd1_data,
  output logic [WORD_SIZE-1:0] rd2_data
);

  logic [WORD_SIZE-1:0] regs_q [32];
  logic [WORD_SIZE-1:0] regs_d [32];
  logic                 wr_live;

  assign wr_live = we && (wr_addr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A same-cycle write wins over the stored value so the decoder sees fresh data.
  always_comb begin
    rd1_data = regs_q[rd1_addr];
    rd2_data = regs_q[rd2_addr];
    if (wr_live && (wr_addr == rd1_addr)) rd1_data = wr_data;
    if (wr_live && (wr_addr == rd2_addr)) rd2_data = wr_data;
    if (rd1_addr == 5'd0) rd1_data = '0;
    if (rd2_addr == 5'd0) rd2_data = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID register, decoder, register file
// read and a fully registered ID/EX output bundle.
module id_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [ADDR_SIZE-1:0] pc_if,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [4:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 ex_valid,
  output logic [ADDR_SIZE-1:0] ex_pc,
  output logic [WORD_SIZE-1:0] ex_rs1_data,
  output logic [WORD_SIZE-1:0] ex_rs2_data,
  output logic [WORD_SIZE-1:0] ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7b5,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_alu_src,
  output logic [1:0]           ex_alu_op,
  output logic                 ex_illegal
);
  import riscv_pkg::*;

  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;

  logic                 ex_valid_q, ex_valid_d;
  ctrl_t                ex_ctrl_q, ex_ctrl_d;
  logic [ADDR_SIZE-1:0] ex_pc_q, ex_pc_d;
  logic [WORD_SIZE-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [WORD_SIZE-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [WORD_SIZE-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]           ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [2:0]           ex_funct3_q, ex_funct3_d;
  logic                 ex_funct7b5_q, ex_funct7b5_d;

  logic [31:0]          ins;
  ctrl_t                dec_ctrl;
  imm_fmt_e             dec_fmt;
  logic [WORD_SIZE-1:0] dec_imm;
  logic [WORD_SIZE-1:0] rs1_rdata, rs2_rdata;

  assign ins = instr_q[31:0];

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr;
      pc_d    = pc_if;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    dec_ctrl = '0;
    dec_fmt  = IMM_NONE;
    case (ins[6:0])
      OPC_LUI:    begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; dec_ctrl.alu_op = ALU_LUI; dec_fmt = IMM_U; end
      OPC_AUIPC:  begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; dec_fmt = IMM_U; end
      OPC_JAL:    begin dec_ctrl.reg_write = 1'b1; dec_ctrl.jump = 1'b1; dec_fmt = IMM_J; end
      OPC_JALR:   begin dec_ctrl.reg_write = 1'b1; dec_ctrl.jump = 1'b1; dec_ctrl.alu_src = 1'b1; dec_fmt = IMM_I; end
      OPC_BRANCH: begin dec_ctrl.branch = 1'b1; dec_ctrl.alu_op = ALU_BRANCH; dec_fmt = IMM_B; end
      OPC_LOAD:   begin dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_read = 1'b1; dec_ctrl.alu_src = 1'b1; dec_fmt = IMM_I; end
      OPC_STORE:  begin dec_ctrl.mem_write = 1'b1; dec_ctrl.alu_src = 1'b1; dec_fmt = IMM_S; end
      OPC_OP_IMM: begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_src = 1'b1; dec_ctrl.alu_op = ALU_FUNCT; dec_fmt = IMM_I; end
      OPC_OP:     begin dec_ctrl.reg_write = 1'b1; dec_ctrl.alu_op = ALU_FUNCT; end
      OPC_SYSTEM: dec_fmt = IMM_I;
      default:    dec_ctrl.illegal = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  assign dec_imm = WORD_SIZE'($signed(gen_imm(dec_fmt, ins)));

  reg_file #(.WORD_SIZE(WORD_SIZE)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data),
    .rd1_addr (ins[19:15]),
    .rd2_addr (ins[24:20]),
    .rd1_data (rs1_rdata),
    .rd2_data (rs2_rdata)
  );

  // Anything other than a live, advancing instruction enters EX as an all-zero bubble.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = '0;
    ex_pc_d       = '0;
    ex_rs1_data_d = '0;
    ex_rs2_data_d = '0;
    ex_imm_d      = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_funct3_d   = '0;
    ex_funct7b5_d = 1'b0;
    if (en && !flush && valid_q) begin
      ex_valid_d    = 1'b1;
      ex_ctrl_d     = dec_ctrl;
      ex_pc_d       = pc_q;
      ex_rs1_data_d = rs1_rdata;
      ex_rs2_data_d = rs2_rdata;
      ex_imm_d      = dec_imm;
      ex_rs1_d      = ins[19:15];
      ex_rs2_d      = ins[24:20];
      ex_rd_d       = ins[11:7];
      ex_funct3_d   = ins[14:12];
      ex_funct7b5_d = ins[30];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q       <= '0;
      pc_q          <= '0;
      valid_q       <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b5  = ex_funct7b5_q;
  assign ex_reg_write = ex_ctrl_q.reg_write;
  assign ex_mem_read  = ex_ctrl_q.mem_read;
  assign ex_mem_write = ex_ctrl_q.mem_write;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_jump      = ex_ctrl_q.jump;
  assign ex_alu_src   = ex_ctrl_q.alu_src;
  assign ex_alu_op    = ex_ctrl_q.alu_op;
  assign ex_illegal   = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected EX bundles are queued when an
// instruction is driven and compared on the edge they are due.
module tb_id_stage;

  localparam int WS = 32;
  localparam int AS = 10;

  localparam logic [31:0] I_ADDI1 = 32'h00500093;
  localparam logic [31:0] I_ADD3  = 32'h000101B3;
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3;
  localparam logic [31:0] I_ADD4  = 32'h00210233;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_ADDI5 = 32'h00500293;
  localparam logic [31:0] I_ADD6  = 32'h00000333;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_JAL   = 32'hFFDFF0EF;
  localparam logic [31:0] I_LW    = 32'h00412403;
  localparam logic [31:0] I_ADD9  = 32'h000284B3;

  // {reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op[1:0], illegal}
  localparam logic [8:0] C_ADDI = 9'b100001100;
  localparam logic [8:0] C_OP   = 9'b100000100;
  localparam logic [8:0] C_BR   = 9'b000100010;
  localparam logic [8:0] C_ILL  = 9'b000000001;
  localparam logic [8:0] C_LUI  = 9'b100001110;
  localparam logic [8:0] C_JAL  = 9'b100010000;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] instr;
  logic [AS-1:0] pc_if;
  logic          en, flush, wb_we;
  logic [4:0]    wb_rd;
  logic [WS-1:0] wb_data;
  logic          ex_valid;
  logic [AS-1:0] ex_pc;
  logic [WS-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [2:0]    ex_funct3;
  logic          ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_branch, ex_jump, ex_alu_src, ex_illegal;
  logic [1:0]    ex_alu_op;

  always #5 clk = ~clk;

  id_stage #(.WORD_SIZE(WS), .NUM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_if(pc_if), .en(en), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal)
  );

  typedef struct {
    int          due;
    string       tag;
    logic        valid;
    logic [8:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [9:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    assert (got === want) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int due, input string tag, input logic valid, input logic [8:0] ctrl,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] rs1d,
                          input logic [31:0] rs2d, input logic [9:0] pc);
    exp_t e;
    e.due = due; e.tag = tag; e.valid = valid; e.ctrl = ctrl; e.rd = rd;
    e.imm = imm; e.rs1d = rs1d; e.rs2d = rs2d; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic push_bubble(input int due, input string tag);
    push_exp(due, tag, 1'b0, 9'd0, 5'd0, 32'd0, 32'd0, 32'd0, 10'd0);
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] i, input logic [9:0] p,
                               input logic e, input logic f, input logic we,
                               input logic [4:0] wrd, input logic [31:0] wd);
    rst = r; instr = i; pc_if = p; en = e; flush = f;
    wb_we = we; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [8:0] ctrl_obs;
    ctrl_obs = {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
                ex_alu_src, ex_alu_op, ex_illegal};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_val($sformatf("e%0d %s due", cyc, e.tag), 32'(e.due), 32'(cyc));
      check_val($sformatf("e%0d %s valid", cyc, e.tag), 32'(ex_valid), 32'(e.valid));
      check_val($sformatf("e%0d %s ctrl", cyc, e.tag), 32'(ctrl_obs), 32'(e.ctrl));
      check_val($sformatf("e%0d %s rd", cyc, e.tag), 32'(ex_rd), 32'(e.rd));
      check_val($sformatf("e%0d %s imm", cyc, e.tag), ex_imm, e.imm);
      check_val($sformatf("e%0d %s rs1_data", cyc, e.tag), ex_rs1_data, e.rs1d);
      check_val($sformatf("e%0d %s rs2_data", cyc, e.tag), ex_rs2_data, e.rs2d);
      check_val($sformatf("e%0d %s pc", cyc, e.tag), 32'(ex_pc), 32'(e.pc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    checkOutput();
  endtask

  initial begin
    applyStimulus(1'b0, 32'd0, 10'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h99);
    push_bubble(1, "reset1"); tick();
    push_bubble(2, "reset2"); tick();
    check_val("valid_q after reset", 32'(dut.valid_q), 32'd0);

    applyStimulus(1'b1, I_ADDI1, 10'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_bubble(3, "fill"); tick();

    applyStimulus(1'b1, I_ADD3, 10'd8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(4, "addi", 1'b1, C_ADDI, 5'd1, 32'd5, 32'd0, 32'd0, 10'd4); tick();

    applyStimulus(1'b1, I_BEQ, 10'd12, 1'b1, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
    push_exp(5, "add_bypass", 1'b1, C_OP, 5'd3, 32'd0, 32'hDEADBEEF, 32'd0, 10'd8); tick();

    applyStimulus(1'b1, I_ADD4, 10'd16, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(6, "beq", 1'b1, C_BR, 5'd25, 32'hFFFFFFF8, 32'd0, 32'd0, 10'd12); tick();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, I_ILL, 10'd99, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      push_bubble(cyc + 1, "stall"); tick();
    end

    applyStimulus(1'b1, I_ILL, 10'd20, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(10, "held_add", 1'b1, C_OP, 5'd4, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 10'd16); tick();

    applyStimulus(1'b1, I_ADDI5, 10'd24, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(11, "illegal", 1'b1, C_ILL, 5'd0, 32'd0, 32'd0, 32'd0, 10'd20); tick();

    applyStimulus(1'b1, I_ILL, 10'd28, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    push_bubble(12, "flush_stall"); tick();
    check_val("valid_q after flush", 32'(dut.valid_q), 32'd0);

    applyStimulus(1'b1, I_ADD6, 10'd32, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    push_bubble(13, "no_reissue"); tick();

    applyStimulus(1'b1, I_LUI, 10'd36, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    push_exp(14, "x0_read", 1'b1, C_OP, 5'd6, 32'd0, 32'd0, 32'd0, 10'd32); tick();

    applyStimulus(1'b1, I_JAL, 10'd40, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(15, "lui", 1'b1, C_LUI, 5'd7, 32'h12345000, 32'd0, 32'd0, 10'd36); tick();

    applyStimulus(1'b1, I_LW, 10'd44, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(16, "jal", 1'b1, C_JAL, 5'd1, 32'hFFFFFFFC, 32'd0, 32'd0, 10'd40); tick();

    applyStimulus(1'b1, I_ILL, 10'd48, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    push_bubble(17, "flush_en"); tick();
    check_val("valid_q after flush_en", 32'(dut.valid_q), 32'd0);

    applyStimulus(1'b1, I_ADDI5, 10'd52, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55);
    push_bubble(18, "refill"); tick();

    applyStimulus(1'b0, I_ADD6, 10'd56, 1'b1, 1'b0, 1'b1, 5'd5, 32'h77);
    push_bubble(19, "mid_reset"); tick();

    applyStimulus(1'b1, I_ADD9, 10'd60, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_bubble(20, "post_reset"); tick();
    check_val("valid_q after reload", 32'(dut.valid_q), 32'd1);

    applyStimulus(1'b1, 32'd0, 10'd64, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_exp(21, "rf_cleared", 1'b1, C_OP, 5'd9, 32'd0, 32'd0, 32'd0, 10'd60); tick();

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total = total + 1;
      failed = failed + 1;
      $error("[TB] FAIL %s never compared got=none expected=due %0d", e.tag, e.due);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
